// File: rtl/div_pkg.sv
// Shared types and constants for the divider bus sequencer.
// State encodings are kept as plain localparams so legacy code can match on raw values.
package div_pkg;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_START = 4'd1;
  localparam logic [3:0] ST_LD_A  = 4'd2;
  localparam logic [3:0] ST_LD_Q  = 4'd3;
  localparam logic [3:0] ST_LD_M  = 4'd4;
  localparam logic [3:0] ST_WAIT  = 4'd5;
  localparam logic [3:0] ST_CAP_R = 4'd6;
  localparam logic [3:0] ST_CAP_Q = 4'd7;
  localparam logic [3:0] ST_RESP  = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_LD_A  = ST_LD_A,
    S_LD_Q  = ST_LD_Q,
    S_LD_M  = ST_LD_M,
    S_WAIT  = ST_WAIT,
    S_CAP_R = ST_CAP_R,
    S_CAP_Q = ST_CAP_Q,
    S_RESP  = ST_RESP
  } div_seq_state_t;

  // Operand slot k appears on the core bus k cycles after the start pulse.
  localparam int OP_SLOT_A = 1;
  localparam int OP_SLOT_Q = 2;
  localparam int OP_SLOT_M = 3;

  localparam logic [7:0] DIV0_QUOT = 8'hFF;

endpackage

// File: rtl/div_bus_sequencer_if.sv
// Request, result and divider-core signals of the sequencer; slave is the sequencer side.
interface div_bus_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_q;
  logic [7:0] in_m;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_quot;
  logic [7:0] out_rem;
  logic       out_div0;
  logic       out_tmo;
  logic       div_start;
  logic [7:0] div_inbus;
  logic       div_done;
  logic [7:0] div_outbus;

  modport slave (
    input  in_valid, in_a, in_q, in_m, out_ready, div_done, div_outbus,
    output in_ready, out_valid, out_quot, out_rem, out_div0, out_tmo, div_start, div_inbus
  );

  modport master (
    output in_valid, in_a, in_q, in_m, out_ready, div_done, div_outbus,
    input  in_ready, out_valid, out_quot, out_rem, out_div0, out_tmo, div_start, div_inbus
  );
endinterface

// File: rtl/div_bus_sequencer_timeout_counter.sv
// Free-running cycle counter with synchronous clear and a terminal-count flag.
// Flag is combinational from the count register; clear takes priority over enable.
module timeout_counter #(
  parameter int CNT_W    = 7,
  parameter int TERM_CNT = 63
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_term = (r_cnt == CNT_W'(TERM_CNT));

endmodule

// File: rtl/div_bus_sequencer.sv
// Serialises A/Q/M onto the divider core bus, collects remainder then quotient, returns a result.
// Result arrives 2 cycles after core done; result is held until out_ready, no new request until then.
module div_bus_sequencer
  import div_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input logic                 clk,
  input logic                 rst,
  div_bus_sequencer_if.slave  bus
);

  div_seq_state_t r_state;
  div_seq_state_t w_next;
  logic [7:0]     r_a;
  logic [7:0]     r_q;
  logic [7:0]     r_m;
  logic [7:0]     r_quot;
  logic [7:0]     r_rem;
  logic           r_div0;
  logic           r_tmo;
  logic           w_accept;
  logic           w_term;
  logic           w_in_wait;
  logic           w_cnt_clr;

  assign w_accept  = bus.in_valid && (r_state == S_IDLE);
  assign w_in_wait = (r_state == S_WAIT);
  assign w_cnt_clr = !w_in_wait || bus.div_done || w_term;

  timeout_counter #(
    .CNT_W    (CNT_W),
    .TERM_CNT (TIMEOUT_CYCLES - 1)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_cnt_clr),
    .i_en   (w_in_wait),
    .o_term (w_term)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (bus.in_m == 8'h00) ? S_RESP : S_START;
      S_START: w_next = S_LD_A;
      S_LD_A:  w_next = S_LD_Q;
      S_LD_Q:  w_next = S_LD_M;
      S_LD_M:  w_next = S_WAIT;
      // done on the terminal cycle still wins over the timeout
      S_WAIT: begin
        if (bus.div_done)  w_next = S_CAP_R;
        else if (w_term)   w_next = S_RESP;
      end
      S_CAP_R: w_next = S_RESP;
      S_RESP:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= 8'h00;
      r_q     <= 8'h00;
      r_m     <= 8'h00;
      r_quot  <= 8'h00;
      r_rem   <= 8'h00;
      r_div0  <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a    <= bus.in_a;
        r_q    <= bus.in_q;
        r_m    <= bus.in_m;
        r_div0 <= (bus.in_m == 8'h00);
        r_tmo  <= 1'b0;
        if (bus.in_m == 8'h00) begin
          r_quot <= DIV0_QUOT;
          r_rem  <= bus.in_q;
        end
      end
      if (w_in_wait) begin
        if (bus.div_done) begin
          r_rem <= bus.div_outbus;
        end else if (w_term) begin
          r_tmo  <= 1'b1;
          r_quot <= 8'h00;
          r_rem  <= 8'h00;
        end
      end
      // quotient follows the remainder on the core bus by one cycle
      if (r_state == S_CAP_R) r_quot <= bus.div_outbus;
    end
  end

  always_comb begin
    bus.div_inbus = 8'h00;
    case (r_state)
      S_LD_A:  bus.div_inbus = r_a;
      S_LD_Q:  bus.div_inbus = r_q;
      S_LD_M:  bus.div_inbus = r_m;
      default: bus.div_inbus = 8'h00;
    endcase
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_RESP);
  assign bus.div_start = (r_state == S_START);
  assign bus.out_quot  = r_quot;
  assign bus.out_rem   = r_rem;
  assign bus.out_div0  = r_div0;
  assign bus.out_tmo   = r_tmo;

endmodule

// File: tb/tb_div_bus_sequencer.sv
// Directed bench for div_bus_sequencer; drives and samples 1 time unit after each rising edge.
module tb_div_bus_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  div_bus_sequencer_if bus();

  div_bus_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(7)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.in_ready !== 1'b1)   begin n_bad++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
    n_cmp++; if (bus.out_quot !== 8'h00)  begin n_bad++; $display("FAIL rst_quot got=%h want=00", bus.out_quot); end
    n_cmp++; if (bus.out_rem !== 8'h00)   begin n_bad++; $display("FAIL rst_rem got=%h want=00", bus.out_rem); end
    n_cmp++; if (bus.out_div0 !== 1'b0)   begin n_bad++; $display("FAIL rst_div0 got=%b want=0", bus.out_div0); end
    n_cmp++; if (bus.out_tmo !== 1'b0)    begin n_bad++; $display("FAIL rst_tmo got=%b want=0", bus.out_tmo); end
    n_cmp++; if (bus.div_start !== 1'b0)  begin n_bad++; $display("FAIL rst_div_start got=%b want=0", bus.div_start); end
    n_cmp++; if (bus.div_inbus !== 8'h00) begin n_bad++; $display("FAIL rst_inbus got=%h want=00", bus.div_inbus); end
    rst = 1'b0;
  endtask

  task automatic test_normal();
    bus.in_a = 8'd0; bus.in_q = 8'd100; bus.in_m = 8'd7; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.div_start !== 1'b1)  begin n_bad++; $display("FAIL norm_start got=%b want=1", bus.div_start); end
    n_cmp++; if (bus.div_inbus !== 8'h00) begin n_bad++; $display("FAIL norm_bus_start got=%h want=00", bus.div_inbus); end
    n_cmp++; if (bus.in_ready !== 1'b0)   begin n_bad++; $display("FAIL norm_in_ready got=%b want=0", bus.in_ready); end
    tick();
    n_cmp++; if (bus.div_start !== 1'b0)  begin n_bad++; $display("FAIL norm_start_len got=%b want=0", bus.div_start); end
    n_cmp++; if (bus.div_inbus !== 8'd0)  begin n_bad++; $display("FAIL norm_bus_a got=%0d want=0", bus.div_inbus); end
    tick();
    n_cmp++; if (bus.div_inbus !== 8'd100) begin n_bad++; $display("FAIL norm_bus_q got=%0d want=100", bus.div_inbus); end
    tick();
    n_cmp++; if (bus.div_inbus !== 8'd7)  begin n_bad++; $display("FAIL norm_bus_m got=%0d want=7", bus.div_inbus); end
    tick();
    n_cmp++; if (bus.div_inbus !== 8'h00) begin n_bad++; $display("FAIL norm_bus_wait got=%h want=00", bus.div_inbus); end
    tick();
    tick();
    bus.div_done = 1'b1; bus.div_outbus = 8'd2;
    tick();
    bus.div_done = 1'b0; bus.div_outbus = 8'd14;
    n_cmp++; if (bus.out_valid !== 1'b0)  begin n_bad++; $display("FAIL norm_early_valid got=%b want=0", bus.out_valid); end
    tick();
    bus.div_outbus = 8'h00;
    n_cmp++; if (bus.out_valid !== 1'b1)  begin n_bad++; $display("FAIL norm_valid got=%b want=1", bus.out_valid); end
    n_cmp++; if (bus.out_quot !== 8'd14)  begin n_bad++; $display("FAIL norm_quot got=%0d want=14", bus.out_quot); end
    n_cmp++; if (bus.out_rem !== 8'd2)    begin n_bad++; $display("FAIL norm_rem got=%0d want=2", bus.out_rem); end
    n_cmp++; if (bus.out_div0 !== 1'b0 || bus.out_tmo !== 1'b0) begin n_bad++; $display("FAIL norm_flags got=%b%b want=00", bus.out_div0, bus.out_tmo); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL norm_release got=%b%b want=01", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_div0();
    bus.in_a = 8'h12; bus.in_q = 8'h35; bus.in_m = 8'h00; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.div_start !== 1'b0)  begin n_bad++; $display("FAIL div0_start got=%b want=0", bus.div_start); end
    n_cmp++; if (bus.out_valid !== 1'b1)  begin n_bad++; $display("FAIL div0_valid got=%b want=1", bus.out_valid); end
    n_cmp++; if (bus.out_quot !== 8'hFF)  begin n_bad++; $display("FAIL div0_quot got=%h want=ff", bus.out_quot); end
    n_cmp++; if (bus.out_rem !== 8'h35)   begin n_bad++; $display("FAIL div0_rem got=%h want=35", bus.out_rem); end
    n_cmp++; if (bus.out_div0 !== 1'b1)   begin n_bad++; $display("FAIL div0_flag got=%b want=1", bus.out_div0); end
    n_cmp++; if (bus.out_tmo !== 1'b0)    begin n_bad++; $display("FAIL div0_tmo got=%b want=0", bus.out_tmo); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.div_start !== 1'b0) begin n_bad++; $display("FAIL div0_release got=%b%b want=00", bus.out_valid, bus.div_start); end
  endtask

  task automatic test_timeout();
    bus.in_a = 8'h01; bus.in_q = 8'h02; bus.in_m = 8'h03; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    repeat (7) tick();
    n_cmp++; if (bus.out_valid !== 1'b0)  begin n_bad++; $display("FAIL tmo_early got=%b want=0", bus.out_valid); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1)  begin n_bad++; $display("FAIL tmo_valid got=%b want=1", bus.out_valid); end
    n_cmp++; if (bus.out_tmo !== 1'b1)    begin n_bad++; $display("FAIL tmo_flag got=%b want=1", bus.out_tmo); end
    n_cmp++; if (bus.out_quot !== 8'h00)  begin n_bad++; $display("FAIL tmo_quot got=%h want=00", bus.out_quot); end
    n_cmp++; if (bus.out_rem !== 8'h00)   begin n_bad++; $display("FAIL tmo_rem got=%h want=00", bus.out_rem); end
    n_cmp++; if (bus.out_div0 !== 1'b0)   begin n_bad++; $display("FAIL tmo_div0 got=%b want=0", bus.out_div0); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_done_on_last();
    bus.in_a = 8'h00; bus.in_q = 8'h63; bus.in_m = 8'h02; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    repeat (7) tick();
    bus.div_done = 1'b1; bus.div_outbus = 8'h01;
    tick();
    bus.div_done = 1'b0; bus.div_outbus = 8'h31;
    n_cmp++; if (bus.out_valid !== 1'b0)  begin n_bad++; $display("FAIL last_early got=%b want=0", bus.out_valid); end
    tick();
    bus.div_outbus = 8'h00;
    n_cmp++; if (bus.out_valid !== 1'b1)  begin n_bad++; $display("FAIL last_valid got=%b want=1", bus.out_valid); end
    n_cmp++; if (bus.out_tmo !== 1'b0)    begin n_bad++; $display("FAIL last_tmo got=%b want=0", bus.out_tmo); end
    n_cmp++; if (bus.out_quot !== 8'h31)  begin n_bad++; $display("FAIL last_quot got=%h want=31", bus.out_quot); end
    n_cmp++; if (bus.out_rem !== 8'h01)   begin n_bad++; $display("FAIL last_rem got=%h want=01", bus.out_rem); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int bad_hold;
    bus.in_a = 8'h00; bus.in_q = 8'h11; bus.in_m = 8'h00; bus.in_valid = 1'b1;
    tick();
    bus.in_a = 8'h00; bus.in_q = 8'h09; bus.in_m = 8'h03;
    bad_hold = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid !== 1'b1 || bus.out_quot !== 8'hFF || bus.out_rem !== 8'h11 ||
          bus.out_div0 !== 1'b1 || bus.in_ready !== 1'b0 || bus.div_start !== 1'b0)
        bad_hold++;
      tick();
    end
    n_cmp++; if (bad_hold !== 0) begin n_bad++; $display("FAIL bp_hold bad_cycles=%0d want=0", bad_hold); end
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_still_valid got=%b want=1", bus.out_valid); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release got=%b%b want=10", bus.in_ready, bus.out_valid); end
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.div_start !== 1'b1) begin n_bad++; $display("FAIL bp_new_start got=%b want=1", bus.div_start); end
    repeat (3) tick();
    n_cmp++; if (bus.div_inbus !== 8'h03) begin n_bad++; $display("FAIL bp_new_m got=%h want=03", bus.div_inbus); end
    tick();
    bus.div_done = 1'b1; bus.div_outbus = 8'h00;
    tick();
    bus.div_done = 1'b0; bus.div_outbus = 8'h03;
    tick();
    bus.div_outbus = 8'h00;
    n_cmp++; if (bus.out_quot !== 8'h03 || bus.out_rem !== 8'h00 || bus.out_div0 !== 1'b0) begin n_bad++; $display("FAIL bp_new_result got=%h/%h/%b want=03/00/0", bus.out_quot, bus.out_rem, bus.out_div0); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    bus.in_a = 8'h00; bus.in_q = 8'd40; bus.in_m = 8'd6; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1)   begin n_bad++; $display("FAIL rmw_in_ready got=%b want=1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0)  begin n_bad++; $display("FAIL rmw_out_valid got=%b want=0", bus.out_valid); end
    n_cmp++; if (bus.div_inbus !== 8'h00) begin n_bad++; $display("FAIL rmw_inbus got=%h want=00", bus.div_inbus); end
    bus.div_done = 1'b1; bus.div_outbus = 8'd4;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.div_done = 1'b0;
      if (bus.out_valid !== 1'b0) seen++;
    end
    bus.div_outbus = 8'h00;
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rmw_no_result valid_cycles=%0d want=0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [2];
    logic [7:0] vq [2];
    logic [7:0] vm [2];
    logic [7:0] eq [2];
    logic [7:0] er [2];
    logic [7:0] got_q [$];
    logic [7:0] got_r [$];
    int busy_bad;
    va[0] = 8'h00; vq[0] = 8'd50;  vm[0] = 8'd5; eq[0] = 8'd10;  er[0] = 8'd0;
    va[1] = 8'hFF; vq[1] = 8'hEC;  vm[1] = 8'd3; eq[1] = 8'hFA;  er[1] = 8'hFE;
    busy_bad = 0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_%0d got=%b want=1", k, bus.in_ready); end
      bus.in_a = va[k]; bus.in_q = vq[k]; bus.in_m = vm[k]; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (bus.in_ready !== 1'b0) busy_bad++;
        tick();
      end
      bus.div_done = 1'b1; bus.div_outbus = er[k];
      if (bus.in_ready !== 1'b0) busy_bad++;
      tick();
      bus.div_done = 1'b0; bus.div_outbus = eq[k];
      if (bus.in_ready !== 1'b0) busy_bad++;
      tick();
      bus.div_outbus = 8'h00;
      if (bus.in_ready !== 1'b0) busy_bad++;
      if (bus.out_valid === 1'b1) begin
        got_q.push_back(bus.out_quot);
        got_r.push_back(bus.out_rem);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    n_cmp++; if (busy_bad !== 0) begin n_bad++; $display("FAIL b2b_busy bad_cycles=%0d want=0", busy_bad); end
    n_cmp++; if (got_q.size() !== 2) begin n_bad++; $display("FAIL b2b_count got=%0d want=2", got_q.size()); end
    for (int k = 0; k < 2; k++) begin
      if (k < got_q.size()) begin
        n_cmp++; if (got_q[k] !== eq[k]) begin n_bad++; $display("FAIL b2b_quot_%0d got=%h want=%h", k, got_q[k], eq[k]); end
        n_cmp++; if (got_r[k] !== er[k]) begin n_bad++; $display("FAIL b2b_rem_%0d got=%h want=%h", k, got_r[k], er[k]); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = 8'h00; bus.in_q = 8'h00; bus.in_m = 8'h00;
    bus.out_ready = 1'b0; bus.div_done = 1'b0; bus.div_outbus = 8'h00;
    test_reset();
    test_normal();
    test_div0();
    test_timeout();
    test_done_on_last();
    test_backpressure();
    test_reset_mid_wait();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
